shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//   Shares one `shifter` datapath instance between NREQ requesters. Round-robin
//   arbitration, operand capture, sequenced start of the shifter, registered
//   result returned with a valid/ready handshake. Sits between client units
//   (ALU front-end, address gen) and the single shared shifter.
// PARAMETERS
//   WIDTH        32  data width; must match `WIDTH of the shifter
//   SHIFT_WIDTH  5   shift-amount width; must match `SHIFT_WIDTH
//   OPS          2   op-code width; must match `OPS
//   NREQ         2   number of requesters, 2..8; IDW = $clog2(NREQ)
// PORTS
//   i_clk     in   1               clock, rising edge
//   i_rst     in   1               synchronous reset, active-high
//   i_req     in   NREQ            per-requester request
//   i_data    in   NREQ*WIDTH      packed operands; slice k = requester k
//   i_shift   in   NREQ*SHIFT_WIDTH packed shift amounts
//   i_op      in   NREQ*OPS        packed ops: 00 ASL(keep MSB) 01 LSL 10 ASR 11 LSR
//   o_gnt     out  NREQ            one-hot grant pulse, one cycle
//   o_valid   out  1               result valid
//   o_id      out  IDW             index of requester owning o_result
//   o_result  out  WIDTH           shift result
//   i_ready   in   1               consumer accepts result when o_valid&i_ready
//   o_busy    out  1               high in any state except IDLE
// BEHAVIOUR
//   Reset (i_rst=1 at a clock edge, regardless of state): state=IDLE,
//     o_gnt=0, o_valid=0, o_id=0, o_result=0, o_busy=0, RR pointer=0.
//     Reset mid-operation discards the in-flight op; no o_valid is produced.
//   FSM: IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: on edge with |i_req: winner = first set bit of i_req searching from
//     RR pointer upward, wrapping NREQ-1 -> 0. Latch winner's data/shift/op
//     and id; o_gnt <= onehot(winner) for exactly one cycle; -> EXEC.
//     No request: stay IDLE, all outputs hold.
//   EXEC: shifter driven from latched operands with i_start=1 (i_start=0 in
//     all other states). On edge: capture shifter output into o_result,
//     o_id <= latched id, o_valid <= 1; -> DONE.
//   DONE: o_valid, o_result, o_id held stable until o_valid&i_ready at an
//     edge; then o_valid <= 0, RR pointer <= (winner+1) mod NREQ, -> IDLE.
//   Latency: req sampled edge N; o_gnt high cycle N+1; o_valid high from
//     edge N+2. Min issue interval 3 cycles (i_ready held high).
//   Requester holds i_req and its operands stable until it sees o_gnt, and
//     drops i_req in the o_gnt cycle unless it has a new op. i_req changes
//     in EXEC/DONE are ignored; arbitration only in IDLE.
//   Op semantics (shift s, 0..2^SHIFT_WIDTH-1): ASL = {d[W-1], (d<<s)[W-2:0]};
//     LSL = d<<s; ASR = sign-fill right shift; LSR = zero-fill right shift.
//     s=0 returns d unchanged for all ops.
//   Fairness: a requester holding i_req continuously is granted within NREQ
//     arbitration rounds. Pointer advances only on result acceptance.
// TESTING
//   1 Reset mid-EXEC: req0 LSL, assert i_rst in EXEC -> next cycle IDLE,
//     o_valid=0, o_busy=0, no result ever emitted for that op.
//   2 Single op: req1, d=32'h0000_00F0, s=4, op=11, i_ready=1 ->
//     o_gnt=2'b10 at N+1, o_valid at N+2 with o_result=32'h0000_000F, o_id=1.
//   3 ASR sign: d=32'h8000_0000, s=31, op=10 -> 32'hFFFF_FFFF; op=11 ->
//     32'h0000_0001; ASL d=32'h8000_0001, s=1 -> 32'h8000_0002.
//   4 Round-robin: req0 and req1 held high, i_ready=1, 4 ops -> grant order
//     0,1,0,1; o_gnt one-hot, never two bits set.
//   5 Backpressure: i_ready=0 for 5 cycles after o_valid -> o_valid,
//     o_result, o_id stable; no new o_gnt; pointer unchanged until accept.
//   6 Boundary: s=0 for each op on d=32'hA5A5_A5A5 -> result equals d;
//     LSL s=31 on 32'h0000_0003 -> 32'h8000_0000.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift datapath between NREQ requesters.
// Captures the winner's operands, executes one shift, and holds the result until accepted.
module shift_arbiter #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = 5,
  parameter int OPS         = 2,
  parameter int NREQ        = 2,
  localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NREQ-1:0]             i_req,
  input  logic [NREQ*WIDTH-1:0]       i_data,
  input  logic [NREQ*SHIFT_WIDTH-1:0] i_shift,
  input  logic [NREQ*OPS-1:0]         i_op,
  output logic [NREQ-1:0]             o_gnt,
  output logic                        o_valid,
  output logic [IDW-1:0]              o_id,
  output logic [WIDTH-1:0]            o_result,
  input  logic                        i_ready,
  output logic                        o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OPS-1:0] OP_ASL = OPS'(0);
  localparam logic [OPS-1:0] OP_LSL = OPS'(1);
  localparam logic [OPS-1:0] OP_ASR = OPS'(2);

  logic [1:0]             state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic                   valid_q, valid_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [WIDTH-1:0]       lat_data_q, lat_data_d;
  logic [SHIFT_WIDTH-1:0] lat_shift_q, lat_shift_d;
  logic [OPS-1:0]         lat_op_q, lat_op_d;
  logic [IDW-1:0]         lat_id_q, lat_id_d;

  // Rotating a doubled request vector by the pointer turns the wrapped search into a plain scan.
  logic [2*NREQ-1:0] req_rot;
  logic              win_found;
  logic [IDW:0]      win_sum;
  logic [IDW-1:0]    win_id;
  logic [IDW:0]      ptr_inc;
  logic [IDW-1:0]    ptr_nxt;

  assign req_rot = {i_req, i_req} >> ptr_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_sum   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, ptr_q} + (IDW+1)'(i);
      end
    end
  end

  assign win_id  = (win_sum >= (IDW+1)'(NREQ)) ? IDW'(win_sum - (IDW+1)'(NREQ)) : win_sum[IDW-1:0];
  assign ptr_inc = {1'b0, lat_id_q} + (IDW+1)'(1);
  assign ptr_nxt = (ptr_inc >= (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];

  logic [WIDTH-1:0] shl_w;
  logic [WIDTH-1:0] shift_res;

  assign shl_w = lat_data_q << lat_shift_q;

  always_comb begin
    shift_res = lat_data_q >> lat_shift_q;
    case (lat_op_q)
      OP_ASL:  shift_res = {lat_data_q[WIDTH-1], shl_w[WIDTH-2:0]};
      OP_LSL:  shift_res = shl_w;
      OP_ASR:  shift_res = $signed(lat_data_q) >>> lat_shift_q;
      default: shift_res = lat_data_q >> lat_shift_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    valid_d     = valid_q;
    id_d        = id_q;
    result_d    = result_q;
    lat_data_d  = lat_data_q;
    lat_shift_d = lat_shift_q;
    lat_op_d    = lat_op_q;
    lat_id_d    = lat_id_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d       = NREQ'(1) << win_id;
          lat_data_d  = i_data[win_id*WIDTH +: WIDTH];
          lat_shift_d = i_shift[win_id*SHIFT_WIDTH +: SHIFT_WIDTH];
          lat_op_d    = i_op[win_id*OPS +: OPS];
          lat_id_d    = win_id;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = shift_res;
        id_d     = lat_id_q;
        valid_d  = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // The pointer only moves on acceptance, so a stalled consumer cannot skew fairness.
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_nxt;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      valid_q     <= 1'b0;
      id_q        <= '0;
      result_q    <= '0;
      lat_data_q  <= '0;
      lat_shift_q <= '0;
      lat_op_q    <= '0;
      lat_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      result_q    <= result_d;
      lat_data_q  <= lat_data_d;
      lat_shift_q <= lat_shift_d;
      lat_op_q    <= lat_op_d;
      lat_id_q    <= lat_id_d;
    end
  end

  assign o_gnt    = gnt_q;
  assign o_valid  = valid_q;
  assign o_id     = id_q;
  assign o_result = result_q;
  assign o_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed cases plus randomized traffic
// compared against an arithmetic shift model and a round-robin pointer model.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [63:0] i_data;
  logic [9:0]  i_shift;
  logic [3:0]  i_op;
  logic [1:0]  o_gnt;
  logic        o_valid;
  logic [0:0]  o_id;
  logic [31:0] o_result;
  logic        i_ready;
  logic        o_busy;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(32), .SHIFT_WIDTH(5), .OPS(2), .NREQ(2)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_data  (i_data),
    .i_shift (i_shift),
    .i_op    (i_op),
    .o_gnt   (o_gnt),
    .o_valid (o_valid),
    .o_id    (o_id),
    .o_result(o_result),
    .i_ready (i_ready),
    .o_busy  (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Shift semantics via multiply/divide by powers of two.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
    longint unsigned p2 = 1;
    longint unsigned ud = {32'd0, d};
    longint unsigned nd = {32'd0, ~d};
    logic [31:0] prod;
    for (int k = 0; k < s; k++) p2 = p2 * 2;
    prod = 32'(ud * p2);
    case (op)
      2'b00:   return {d[31], prod[30:0]};
      2'b01:   return prod;
      2'b10:   return d[31] ? ~32'(nd / p2) : 32'(ud / p2);
      default: return 32'(ud / p2);
    endcase
  endfunction

  function automatic int pick(input logic [1:0] req, input int ptr);
    for (int k = 0; k < 2; k++) begin
      int idx = (ptr + k) % 2;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic issue(input logic [1:0] req,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] op0, input logic [1:0] op1,
                       input int stall, input bit hold);
    int w;
    logic [31:0] exp_r;
    i_req   = req;
    i_data  = {d1, d0};
    i_shift = {s1, s0};
    i_op    = {op1, op0};
    i_ready = 1'b0;
    w = pick(req, ptr_m);
    exp_r = (w == 1) ? ref_shift(d1, int'(s1), op1) : ref_shift(d0, int'(s0), op0);
    @(posedge clk); #1;
    check("gnt", {62'd0, o_gnt}, 64'd1 << w);
    check("busy_exec", {63'd0, o_busy}, 64'd1);
    check("valid_exec", {63'd0, o_valid}, 64'd0);
    if (!hold) i_req = 2'b00;
    @(posedge clk); #1;
    check("valid", {63'd0, o_valid}, 64'd1);
    check("result", {32'd0, o_result}, {32'd0, exp_r});
    check("id", {63'd0, o_id}, 64'(w));
    check("gnt_pulse", {62'd0, o_gnt}, 64'd0);
    if (stall > 0) i_req = 2'b11;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'd0, o_valid}, 64'd1);
      check("stall_result", {32'd0, o_result}, {32'd0, exp_r});
      check("stall_id", {63'd0, o_id}, 64'(w));
      check("stall_gnt", {62'd0, o_gnt}, 64'd0);
    end
    i_ready = 1'b1;
    i_req   = hold ? req : 2'b00;
    @(posedge clk); #1;
    check("accept_valid", {63'd0, o_valid}, 64'd0);
    check("accept_busy", {63'd0, o_busy}, 64'd0);
    ptr_m   = (w + 1) % 2;
    i_ready = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_req = '0; i_data = '0; i_shift = '0; i_op = '0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {62'd0, o_gnt}, 64'd0);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_id", {63'd0, o_id}, 64'd0);
    check("rst_result", {32'd0, o_result}, 64'd0);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    i_rst = 1'b0;

    // Reset while EXEC: the in-flight op must vanish.
    i_req = 2'b01; i_data = {32'd0, 32'h0000_0001}; i_shift = {5'd0, 5'd3}; i_op = {2'b00, 2'b01};
    @(posedge clk); #1;
    check("mid_gnt", {62'd0, o_gnt}, 64'd1);
    i_req = 2'b00;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    check("mid_rst_gnt", {62'd0, o_gnt}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle_valid", {63'd0, o_valid}, 64'd0);
      check("idle_busy", {63'd0, o_busy}, 64'd0);
    end
    ptr_m = 0;

    // Single op, ASR/LSR/ASL sign cases, s=0 and LSL s=31 boundaries.
    issue(2'b10, 32'h0, 32'h0000_00F0, 5'd0, 5'd4, 2'b00, 2'b11, 0, 1'b0);
    issue(2'b01, 32'h8000_0000, 32'h0, 5'd31, 5'd0, 2'b10, 2'b00, 0, 1'b0);
    issue(2'b01, 32'h8000_0000, 32'h0, 5'd31, 5'd0, 2'b11, 2'b00, 0, 1'b0);
    issue(2'b01, 32'h8000_0001, 32'h0, 5'd1, 5'd0, 2'b00, 2'b00, 0, 1'b0);
    check("asr_abs", {32'd0, o_result}, 64'h8000_0002);
    for (int op = 0; op < 4; op++)
      issue(2'b10, 32'h0, 32'hA5A5_A5A5, 5'd0, 5'd0, 2'b00, 2'(op), 0, 1'b0);
    check("s0_abs", {32'd0, o_result}, 64'hA5A5_A5A5);
    issue(2'b01, 32'h0000_0003, 32'h0, 5'd31, 5'd0, 2'b01, 2'b00, 0, 1'b0);
    check("lsl31_abs", {32'd0, o_result}, 64'h8000_0000);

    // Round-robin with both requesters held and a stalled consumer.
    for (int k = 0; k < 4; k++)
      issue(2'b11, 32'h1111_0000 + 32'(k), 32'h2222_0000 + 32'(k), 5'(k), 5'(k + 1), 2'b01, 2'b11, (k == 1) ? 5 : 0, 1'b1);
    i_req = 2'b00;

    for (int n = 0; n < 40; n++) begin
      logic [4:0] s0, s1;
      s0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1) * 31) : 5'($urandom);
      s1 = 5'($urandom);
      issue(2'($urandom_range(1, 3)), $urandom, $urandom, s0, s1,
            2'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
